// File: rtl/mux_4x1_using_2x1_pkg.sv
// Shared constants for the 4:1 lane selector: select codes and lane count.
// Latency: none (constants only).
// Backpressure: not applicable.
package mux_4x1_using_2x1_pkg;

    // Select codes, {S1,S0}, naming the lane each code steers to the output.
    localparam logic [1:0] SEL_I0 = 2'd0;
    localparam logic [1:0] SEL_I1 = 2'd1;
    localparam logic [1:0] SEL_I2 = 2'd2;
    localparam logic [1:0] SEL_I3 = 2'd3;

    // Number of data lanes packed into the selector's input bus.
    localparam int NUM_LANES = 4;

endpackage : mux_4x1_using_2x1_pkg

// File: rtl/mux_4x1_using_2x1_mux_2x1.sv
// Gate-level 2:1 cell, per bit y = (a & ~s) | (b & s), built from primitives.
// Latency: combinational, inverter -> AND -> OR.
// Backpressure: none; output follows inputs at all times.
module mux_2x1_gate #(
    parameter int WIDTH = 1
) (
    output wire  [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s
);

    wire [WIDTH-1:0] s_n;
    wire [WIDTH-1:0] and_a;
    wire [WIDTH-1:0] and_b;

    // One inverter, two ANDs and one OR per bit; the select inverter is
    // replicated per bit so each slice is a self-contained cell.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        not u_inv  (s_n[g],   s);
        and u_and_a(and_a[g], a[g], s_n[g]);
        and u_and_b(and_b[g], b[g], s);
        or  u_or   (y[g],     and_a[g], and_b[g]);
    end

endmodule : mux_2x1_gate

// File: rtl/mux_4x1_using_2x1.sv
// 4:1 lane selector as a two-level tree of gate-level 2:1 cells, plus a registered copy.
// Latency: Y combinational (two cells deep); Y_q one clk cycle, sync reset to zero.
// Backpressure: none; no handshake, Y_q loads every edge.
module mux_4x1_using_2x1
    import mux_4x1_using_2x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0]           Y,
    input  logic [NUM_LANES*WIDTH-1:0] I,
    input  logic [1:0]                 S,
    input  logic                       clk,
    input  logic                       rst,
    output logic [WIDTH-1:0]           Y_q
);

    logic [WIDTH-1:0] lane [NUM_LANES];
    logic [WIDTH-1:0] low_pair;
    logic [WIDTH-1:0] high_pair;

    // Lane k sits at I[k*WIDTH +: WIDTH].
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane[k] = I[k*WIDTH +: WIDTH];
    end

    // First level: S0 picks within each pair of lanes.
    mux_2x1_gate #(.WIDTH(WIDTH)) u_cell_a (
        .y (low_pair),
        .a (lane[SEL_I0]),
        .b (lane[SEL_I1]),
        .s (S[0])
    );

    mux_2x1_gate #(.WIDTH(WIDTH)) u_cell_b (
        .y (high_pair),
        .a (lane[SEL_I2]),
        .b (lane[SEL_I3]),
        .s (S[0])
    );

    // Second level: S1 picks between the two pairs.
    mux_2x1_gate #(.WIDTH(WIDTH)) u_cell_c (
        .y (Y),
        .a (low_pair),
        .b (high_pair),
        .s (S[1])
    );

    // Registered copy of the selected lane; reset clears only this register.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q <= '0;
        end else begin
            Y_q <= Y;
        end
    end

endmodule : mux_4x1_using_2x1

// File: tb/tb_mux_4x1_using_2x1.sv
// Self-checking bench for the 4:1 selector at WIDTH=1 and WIDTH=8.
// Inputs are driven on the falling edge, outputs sampled 1 time unit later.
// Y_q is checked 1 time unit after each rising edge.
module tb_mux_4x1_using_2x1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i1;
    logic [1:0]  s1;
    logic [0:0]  y1;
    logic [0:0]  yq1;
    logic [31:0] i8;
    logic [1:0]  s8;
    logic [7:0]  y8;
    logic [7:0]  yq8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_4x1_using_2x1 #(.WIDTH(1)) dut1 (
        .Y   (y1),
        .I   (i1),
        .S   (s1),
        .clk (clk),
        .rst (rst),
        .Y_q (yq1)
    );

    mux_4x1_using_2x1 #(.WIDTH(8)) dut8 (
        .Y   (y8),
        .I   (i8),
        .S   (s8),
        .clk (clk),
        .rst (rst),
        .Y_q (yq8)
    );

    // Reference: shift the packed lanes right by sel lanes and keep one lane.
    function automatic logic [7:0] ref_sel(input logic [31:0] lanes,
                                           input logic [1:0] sel, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return 8'((lanes >> (int'(sel) * w)) & mask);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full cycle: drive, check Y, cross the rising edge, check Y_q.
    task automatic step(input logic r, input logic [3:0] a1, input logic [1:0] b1,
                        input logic [31:0] a8, input logic [1:0] b8, input string tag);
        logic [7:0] e1;
        logic [7:0] e8;
        @(negedge clk);
        rst = r; i1 = a1; s1 = b1; i8 = a8; s8 = b8;
        e1 = ref_sel({28'd0, a1}, b1, 1);
        e8 = ref_sel(a8, b8, 8);
        #1;
        check({tag, "_y1"}, 8'(y1), e1);
        check({tag, "_y8"}, y8, e8);
        @(posedge clk);
        #1;
        check({tag, "_yq1"}, 8'(yq1), r ? 8'd0 : e1);
        check({tag, "_yq8"}, yq8, r ? 8'd0 : e8);
    endtask

    initial begin
        logic [7:0] pat;
        logic       exp_glitch [4];
        logic [1:0] sel_glitch [4];
        rst = 1'b1; i1 = 4'b1111; s1 = 2'b00;
        i8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1}; s8 = 2'b10;

        // Reset held for two edges; Y keeps following the inputs.
        step(1'b1, 4'b1111, 2'b00, 32'hD4C3B2A1, 2'b10, "rst_hold0");
        step(1'b1, 4'b1111, 2'b00, 32'hD4C3B2A1, 2'b10, "rst_hold1");
        // Release: Y_q loads the current Y.
        step(1'b0, 4'b1111, 2'b00, 32'hD4C3B2A1, 2'b10, "rst_release");

        // Exhaustive WIDTH=1 sweep of {I,S}.
        for (int n = 0; n < 256; n++) begin
            pat = 8'(n);
            step(1'b0, pat[5:2], pat[1:0], 32'hD4C3B2A1, pat[1:0], "sweep");
        end

        // One-hot lanes against every select code.
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 4; s++) begin
                @(negedge clk);
                i1 = 4'(1 << k); s1 = 2'(s);
                #1;
                check("onehot", 8'(y1), (k == s) ? 8'd1 : 8'd0);
            end
        end

        // Select walk with fixed data 0110.
        sel_glitch = '{2'b00, 2'b01, 2'b11, 2'b10};
        exp_glitch = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            i1 = 4'b0110; s1 = sel_glitch[n];
            #1;
            check("sel_walk", 8'(y1), 8'(exp_glitch[n]));
        end

        // Registered path: reset, release, then select a zero lane.
        step(1'b1, 4'b1111, 2'b11, 32'hD4C3B2A1, 2'b10, "reg_rst0");
        step(1'b1, 4'b1111, 2'b11, 32'hD4C3B2A1, 2'b10, "reg_rst1");
        step(1'b0, 4'b0111, 2'b00, 32'hD4C3B2A1, 2'b10, "reg_load1");
        @(negedge clk);
        s1 = 2'b11;
        #1;
        check("zero_lane_y", 8'(y1), 8'd0);
        check("zero_lane_yq_before", 8'(yq1), 8'd1);
        @(posedge clk);
        #1;
        check("zero_lane_yq_after", 8'(yq1), 8'd0);

        // Mid-stream reset for a single edge.
        step(1'b0, 4'b1111, 2'b01, 32'hD4C3B2A1, 2'b11, "mid_pre");
        step(1'b1, 4'b1111, 2'b01, 32'hD4C3B2A1, 2'b11, "mid_rst");
        step(1'b0, 4'b1111, 2'b01, 32'hD4C3B2A1, 2'b11, "mid_post");

        // WIDTH=8 lane values with explicit expectations.
        @(negedge clk);
        i8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1}; s8 = 2'b10;
        #1;
        check("w8_s10", y8, 8'hC3);
        @(posedge clk);
        #1;
        check("w8_s10_q", yq8, 8'hC3);
        @(negedge clk);
        s8 = 2'b11;
        #1;
        check("w8_s11", y8, 8'hD4);
        check("w8_s11_q_before", yq8, 8'hC3);
        @(posedge clk);
        #1;
        check("w8_s11_q", yq8, 8'hD4);

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            step(($urandom % 10) == 0, 4'($urandom), 2'($urandom), $urandom, 2'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_4x1_using_2x1
